// File: rtl/sdram_ram_arbiter.sv
// rtl/sdram_ram_arbiter.sv - round-robin, burst-locking arbiter sharing the SDRAM core word port
module sdram_ram_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_rd_i,
    input  logic [4*NUM_REQ-1:0]    req_wr_i,
    input  logic [32*NUM_REQ-1:0]   req_addr_i,
    input  logic [8*NUM_REQ-1:0]    req_len_i,
    input  logic [32*NUM_REQ-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]      req_accept_o,
    output logic [NUM_REQ-1:0]      req_ack_o,
    output logic [NUM_REQ-1:0]      req_error_o,
    output logic [32*NUM_REQ-1:0]   req_rdata_o,
    output logic                    ram_rd_o,
    output logic [3:0]              ram_wr_o,
    output logic [31:0]             ram_addr_o,
    output logic [7:0]              ram_len_o,
    output logic [31:0]             ram_wdata_o,
    input  logic                    ram_accept_i,
    input  logic                    ram_ack_i,
    input  logic                    ram_error_i,
    input  logic [31:0]             ram_rdata_i
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t             state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      lock_owner;
    logic [7:0]         beat_cnt;

    logic [IW-1:0]      owner_mem [OUTSTANDING];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    logic [NUM_REQ-1:0] active;
    logic [IW-1:0]      grant;
    logic [IW-1:0]      next_rr;
    logic [IW-1:0]      head;
    logic [7:0]         grant_len;
    logic               grant_valid;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fwd;
    logic               accept;
    logic               pop;
    int                 cand;

    always_comb begin
        active = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            active[i] = req_rd_i[i] | (|req_wr_i[i*4 +: 4]);
        end
    end

    // Descending scan so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        grant       = lock_owner;
        grant_valid = 1'b0;
        cand        = 0;
        if (state == ST_LOCKED) begin
            grant_valid = active[lock_owner];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (active[IW'(cand)]) begin
                    grant       = IW'(cand);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign next_rr    = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    assign grant_len  = req_len_i[{grant, 3'b000} +: 8];
    assign fifo_full  = (count == CW'(OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign fwd        = rst_ni & grant_valid & ~fifo_full;
    assign accept     = fwd & ram_accept_i;
    assign pop        = ram_ack_i & ~fifo_empty;
    assign head       = owner_mem[rd_ptr];

    always_comb begin
        ram_rd_o     = 1'b0;
        ram_wr_o     = 4'h0;
        ram_addr_o   = 32'h0;
        ram_len_o    = 8'h0;
        ram_wdata_o  = 32'h0;
        req_accept_o = '0;
        if (fwd) begin
            ram_rd_o            = req_rd_i[grant];
            ram_wr_o            = req_wr_i[{grant, 2'b00} +: 4];
            ram_addr_o          = req_addr_i[{grant, 5'b00000} +: 32];
            ram_len_o           = grant_len;
            ram_wdata_o         = req_wdata_i[{grant, 5'b00000} +: 32];
            req_accept_o[grant] = ram_accept_i;
        end
    end

    always_comb begin
        req_ack_o   = '0;
        req_error_o = '0;
        req_rdata_o = '0;
        if (pop) begin
            req_ack_o[head]   = 1'b1;
            req_error_o[head] = ram_error_i;
            req_rdata_o       = {NUM_REQ{ram_rdata_i}};
        end
    end

    // beat_cnt holds the beats still owed after the current one; 1 means the last beat is pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            lock_owner <= '0;
            beat_cnt   <= 8'h0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                if (grant_len != 8'h0) begin
                    state      <= ST_LOCKED;
                    lock_owner <= grant;
                    beat_cnt   <= grant_len;
                end else begin
                    rr_ptr <= next_rr;
                end
            end else begin
                if (beat_cnt == 8'd1) begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_rr;
                end else begin
                    beat_cnt <= beat_cnt - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            owner_mem[wr_ptr] <= grant;
        end
    end
endmodule

// File: tb/tb_sdram_ram_arbiter.sv
// tb/tb_sdram_ram_arbiter.sv - directed and randomized checks of sdram_ram_arbiter against a queue model
module tb_sdram_ram_arbiter;
    localparam int NR  = 2;
    localparam int OUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_rd;
    logic [4*NR-1:0]   req_wr;
    logic [32*NR-1:0]  req_addr;
    logic [8*NR-1:0]   req_len;
    logic [32*NR-1:0]  req_wdata;
    logic [NR-1:0]     req_accept;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     req_error;
    logic [32*NR-1:0]  req_rdata;
    logic              ram_rd;
    logic [3:0]        ram_wr;
    logic [31:0]       ram_addr;
    logic [7:0]        ram_len;
    logic [31:0]       ram_wdata;
    logic              ram_accept;
    logic              ram_ack;
    logic              ram_error;
    logic [31:0]       ram_rdata;

    sdram_ram_arbiter #(.NUM_REQ(NR), .OUTSTANDING(OUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_rd_i     (req_rd),
        .req_wr_i     (req_wr),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .req_wdata_i  (req_wdata),
        .req_accept_o (req_accept),
        .req_ack_o    (req_ack),
        .req_error_o  (req_error),
        .req_rdata_o  (req_rdata),
        .ram_rd_o     (ram_rd),
        .ram_wr_o     (ram_wr),
        .ram_addr_o   (ram_addr),
        .ram_len_o    (ram_len),
        .ram_wdata_o  (ram_wdata),
        .ram_accept_i (ram_accept),
        .ram_ack_i    (ram_ack),
        .ram_error_i  (ram_error),
        .ram_rdata_i  (ram_rdata)
    );

    always #5 clk = ~clk;

    bit          a_act   [NR];
    bit          a_rd    [NR];
    logic [3:0]  a_wr    [NR];
    logic [31:0] a_addr  [NR];
    logic [7:0]  a_len   [NR];
    logic [31:0] a_wdata [NR];
    int          a_left  [NR];
    int          a_reps  [NR];

    bit          rand_mode;
    bit          force_stray;
    bit          fix_en;
    logic [31:0] fix_rdata;
    int          acc_prob;
    int          ack_prob;
    int          err_prob;

    bit          m_locked;
    int          m_owner;
    int          m_left;
    int          m_rr;
    int          owners[$];
    int          acc_log[$];

    logic [NR-1:0] obs_acc;
    logic [NR-1:0] obs_ack;
    logic [NR-1:0] obs_err;
    logic          obs_rd;
    logic [31:0]   obs_rdata0;

    int n_checks;
    int n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic start_burst(input int i, input bit is_rd, input int len,
                               input logic [31:0] addr, input int reps);
        a_act[i]   = 1'b1;
        a_rd[i]    = is_rd;
        a_wr[i]    = is_rd ? 4'h0 : 4'($urandom_range(1, 15));
        a_addr[i]  = addr;
        a_len[i]   = 8'(len);
        a_wdata[i] = $urandom;
        a_left[i]  = len + 1;
        a_reps[i]  = reps;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_rd[i]             = a_act[i] && a_rd[i];
            req_wr[i*4 +: 4]      = a_act[i] ? a_wr[i] : 4'h0;
            req_addr[i*32 +: 32]  = a_addr[i];
            req_len[i*8 +: 8]     = a_len[i];
            req_wdata[i*32 +: 32] = a_wdata[i];
        end
    endtask

    task automatic model_accept(input int g);
        owners.push_back(g);
        if (!m_locked) begin
            if (a_len[g] != 8'h0) begin
                m_locked = 1'b1;
                m_owner  = g;
                m_left   = int'(a_len[g]);
            end else begin
                m_rr = (g + 1) % NR;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_locked = 1'b0;
                m_rr     = (g + 1) % NR;
            end
        end
    endtask

    task automatic agent_tick(input int acc_i);
        for (int i = 0; i < NR; i++) begin
            if (i == acc_i) begin
                a_left[i]--;
                a_addr[i]  = a_addr[i] + 32'd4;
                a_wdata[i] = $urandom;
                if (a_left[i] == 0) begin
                    a_act[i] = 1'b0;
                    a_reps[i]--;
                    if (a_reps[i] > 0) begin
                        start_burst(i, a_rd[i], int'(a_len[i]), a_addr[i], a_reps[i]);
                    end
                end else if (rand_mode) begin
                    a_act[i] = ($urandom_range(0, 3) != 0);
                end
            end else if (rand_mode && !a_act[i]) begin
                if (a_left[i] > 0) begin
                    a_act[i] = ($urandom_range(0, 1) == 1);
                end else if ($urandom_range(0, 99) < 30) begin
                    start_burst(i, $urandom_range(0, 1) == 1,
                                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
                                $urandom, 1);
                end
            end
        end
    endtask

    task automatic step();
        int            g;
        int            first;
        bit            fwd;
        bit            pop;
        logic [NR-1:0] exp_acc;
        logic [NR-1:0] exp_ack;
        logic [NR-1:0] exp_err;
        @(posedge clk);
        #1;
        drive_inputs();
        ram_accept = ($urandom_range(0, 99) < acc_prob);
        ram_ack    = force_stray || (owners.size() > 0 && $urandom_range(0, 99) < ack_prob);
        ram_error  = ram_ack && ($urandom_range(0, 99) < err_prob);
        ram_rdata  = fix_en ? fix_rdata : $urandom;
        #4;
        g = -1;
        if (m_locked) begin
            if (a_act[m_owner]) g = m_owner;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && a_act[(m_rr + k) % NR]) g = (m_rr + k) % NR;
            end
        end
        fwd     = (g >= 0) && (owners.size() < OUT);
        exp_acc = '0;
        exp_ack = '0;
        exp_err = '0;
        if (fwd) begin
            chk("ram_rd", ram_rd, a_rd[g]);
            chk("ram_wr", ram_wr, a_wr[g]);
            chk("ram_addr", ram_addr, a_addr[g]);
            chk("ram_len", ram_len, a_len[g]);
            chk("ram_wdata", ram_wdata, a_wdata[g]);
            exp_acc[g] = ram_accept;
        end else begin
            chk("idle_strobes", {ram_rd, ram_wr}, 5'h0);
        end
        chk("accept", req_accept, exp_acc);
        pop = ram_ack && owners.size() > 0;
        if (pop) begin
            exp_ack[owners[0]] = 1'b1;
            exp_err[owners[0]] = ram_error;
            chk("rdata", req_rdata[owners[0]*32 +: 32], ram_rdata);
        end
        chk("ack", req_ack, exp_ack);
        chk("error", req_error, exp_err);

        obs_acc    = req_accept;
        obs_ack    = req_ack;
        obs_err    = req_error;
        obs_rd     = ram_rd;
        obs_rdata0 = req_rdata[31:0];
        first      = -1;
        for (int i = NR - 1; i >= 0; i--) begin
            if (req_accept[i]) first = i;
        end
        if (first >= 0) acc_log.push_back(first);

        if (pop) void'(owners.pop_front());
        if (fwd && ram_accept) model_accept(g);
        agent_tick((fwd && ram_accept) ? g : -1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rd", ram_rd, 0);
        chk("rst_wr", ram_wr, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_accept", req_accept, 0);
        chk("rst_ack", req_ack, 0);
        for (int i = 0; i < NR; i++) begin
            a_act[i]  = 1'b0;
            a_left[i] = 0;
            a_reps[i] = 0;
        end
        drive_inputs();
        ram_ack     = 1'b0;
        ram_accept  = 1'b0;
        ram_error   = 1'b0;
        force_stray = 1'b0;
        fix_en      = 1'b0;
        rand_mode   = 1'b0;
        err_prob    = 0;
        m_locked    = 1'b0;
        m_owner     = 0;
        m_left      = 0;
        m_rr        = 0;
        owners.delete();
        acc_log.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int pp_cnt;
    int drain_acks;

    initial begin
        rst_n    = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < NR; i++) begin
            a_act[i] = 1'b0; a_rd[i] = 1'b0; a_wr[i] = 4'h0; a_addr[i] = 32'h0;
            a_len[i] = 8'h0; a_wdata[i] = 32'h0; a_left[i] = 0; a_reps[i] = 0;
        end
        drive_inputs();
        ram_accept = 1'b0; ram_ack = 1'b0; ram_error = 1'b0; ram_rdata = 32'h0;
        fix_rdata  = 32'h0;
        do_reset();

        // single requester read
        acc_prob = 100; ack_prob = 0;
        start_burst(0, 1'b1, 0, 32'h100, 1);
        step();
        chk("t1_accept", obs_acc, 2'b01);
        fix_en = 1'b1; fix_rdata = 32'hDEADBEEF; ack_prob = 100;
        step();
        chk("t1_ack", obs_ack, 2'b01);
        chk("t1_rdata", obs_rdata0, 32'hDEADBEEF);

        // contention with single beats alternates
        do_reset();
        acc_prob = 100; ack_prob = 100;
        start_burst(0, 1'b1, 0, 32'h1000, 2);
        start_burst(1, 1'b0, 0, 32'h2000, 2);
        for (int k = 0; k < 20 && acc_log.size() < 4; k++) step();
        chk("rr_count", acc_log.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_order%0d", k), (k < acc_log.size()) ? acc_log[k] : -1, k % 2);

        // burst lock with core stalls
        do_reset();
        acc_prob = 100; ack_prob = 100;
        start_burst(1, 1'b1, 3, 32'h3000, 1);
        for (int k = 0; k < 10 && acc_log.size() < 1; k++) step();
        start_burst(0, 1'b0, 0, 32'h4000, 1);
        acc_prob = 50;
        for (int k = 0; k < 80 && acc_log.size() < 5; k++) step();
        chk("lock_count", acc_log.size(), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("lock_order%0d", k), (k < acc_log.size()) ? acc_log[k] : -1, (k < 4) ? 1 : 0);

        // owner FIFO full
        do_reset();
        acc_prob = 100; ack_prob = 0;
        start_burst(0, 1'b1, 0, 32'h5000, 10);
        repeat (8) step();
        chk("full_accepts", acc_log.size(), 4);
        chk("full_rd_blocked", obs_rd, 0);
        ack_prob = 100;
        step();
        ack_prob = 0;
        repeat (4) step();
        chk("full_one_more", acc_log.size(), 5);
        chk("full_rd_blocked2", obs_rd, 0);

        // simultaneous push/pop with errors
        do_reset();
        acc_prob = 100; ack_prob = 100; err_prob = 100;
        start_burst(0, 1'b1, 0, 32'h6000, 6);
        start_burst(1, 1'b1, 0, 32'h7000, 6);
        pp_cnt = 0;
        repeat (10) begin
            step();
            if (obs_acc != 0 && obs_ack != 0 && $countones(obs_err) == 1 && obs_err == obs_ack)
                pp_cnt++;
        end
        chk("pp_cycles", pp_cnt, 9);
        acc_prob = 0; err_prob = 0;
        drain_acks = 0;
        repeat (4) begin
            step();
            if (obs_ack != 0) drain_acks++;
        end
        chk("pp_drain_acks", drain_acks, 1);

        // reset in the middle of a len=7 burst
        do_reset();
        acc_prob = 100; ack_prob = 0;
        start_burst(1, 1'b0, 7, 32'h8000, 1);
        repeat (3) step();
        do_reset();
        force_stray = 1'b1;
        step();
        force_stray = 1'b0;
        chk("stray_ack", obs_ack, 0);
        start_burst(0, 1'b1, 0, 32'h9000, 1);
        start_burst(1, 1'b1, 0, 32'hA000, 1);
        for (int k = 0; k < 10 && acc_log.size() < 1; k++) step();
        chk("post_rst_first", (acc_log.size() > 0) ? acc_log[0] : -1, 0);

        // 256-beat burst
        do_reset();
        acc_prob = 100; ack_prob = 100;
        start_burst(0, 1'b1, 255, 32'h0, 1);
        start_burst(1, 1'b1, 0, 32'hB000, 1);
        for (int k = 0; k < 400 && acc_log.size() < 257; k++) step();
        chk("b256_count", acc_log.size(), 257);
        chk("b256_last0", (acc_log.size() > 255) ? acc_log[255] : -1, 0);
        chk("b256_then1", (acc_log.size() > 256) ? acc_log[256] : -1, 1);

        // randomized traffic
        do_reset();
        rand_mode = 1'b1;
        acc_prob = 70; ack_prob = 50; err_prob = 20;
        repeat (600) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
